cpu_trace_emitter: RTL and testbench
====================================

Name: cpu_trace_emitter

Overview:
Serializer for CPU write-back trace records. It accepts one register-write or memory-write record per handshake and emits it one ASCII character per beat, in the trace line format our trace checkers parse:
- Register write: "^<time>@<pc>: $<reg> <= <data>#"
- Memory write: "^<time>@<pc>: *<addr> <= <data>#"

It sits between the CPU's write-back/store observation port and the character stream consumed by the trace checker or the UART.

Parameters:
- TIME_MAX, 9999: time values above this saturate to TIME_MAX before conversion; must be 9999 or less.
- IDLE_GAP, 0: forced idle cycles after the final character before in_ready reasserts.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  record offered
- in_ready  output  1  emitter can accept a record
- in_kind  input  1  0 = register write ($), 1 = memory write (*)
- in_time  input  14  cycle stamp, binary
- in_pc  input  32  instruction address
- in_reg  input  5  destination register, used when in_kind = 0
- in_addr  input  32  memory address, used when in_kind = 1
- in_data  input  32  written value
- out_char  output  8  ASCII character
- out_valid  output  1  out_char is valid
- out_ready  input  1  downstream consumes out_char
- busy  output  1  high from accept until return to IDLE
- rec_done  output  1  one-cycle pulse on the beat the final character is consumed

Behaviour:
Reset values:
- in_ready = 1, out_valid = 0, out_char = 8'h00, busy = 0, rec_done = 0.
- State is IDLE, all captured fields are cleared.

Accept:
- Occurs on a clk edge with in_valid & in_ready.
- All in_* fields are latched into internal registers.
- in_ready drops to 0 in the next cycle; busy rises in the next cycle.
- Inputs are ignored while in_ready = 0.

States (IDLE -> CONV -> EMIT -> GAP -> IDLE):
- CONV:
  - Saturate the time value: min(in_time, TIME_MAX).
  - Run a sequential double-dabble binary-to-BCD conversion, one shift per cycle, exactly 14 cycles, producing 4 BCD digits.
  - Register number is split into tens/ones combinationally.
  - out_valid = 0 throughout CONV.
- EMIT:
  - A 5-bit character index walks the field sequence.
  - out_valid = 1 for the whole of EMIT.
  - The index advances only on out_valid & out_ready; out_char is held stable while stalled.
  - Sequence: '^'; time digits with leading zeros suppressed (time 0 emits "0"); '@'; pc as 8 lowercase hex digits, MSB first; ':'; ' '.
  - Then, if kind = 0: '$', reg in decimal without leading zeros (1 or 2 digits).
  - Then, if kind = 1: '*', addr as 8 lowercase hex digits.
  - Then ' ', '<', '=', ' '; data as 8 lowercase hex digits; '#'.
  - Hex nibble encoding: 0-9 map to 8'h30-8'h39; a-f map to 8'h61-8'h66.
- Exit from EMIT:
  - Consumption of '#' pulses rec_done in the same cycle.
  - Next state is GAP if IDLE_GAP > 0, otherwise IDLE.
  - in_ready reasserts the cycle after '#' is consumed, or IDLE_GAP cycles later.
- Latency: accept to first out_valid = 15 cycles (1 capture cycle + 14 CONV cycles).
- Back-to-back records: with out_ready tied high, the next accept may occur in the cycle in_ready returns. No overlap of records.
- Reset mid-record: the record is abandoned; out_valid = 0 the cycle after reset. A partial line is never completed.
- out_ready asserted while out_valid = 0 has no effect.

Optional Feature:
Macro TRACE_NEWLINE_EN.
- Defined: after '#', one extra character 8'h0A is emitted. rec_done pulses on consumption of the 8'h0A beat instead of '#'.
- Undefined: the line ends at '#', with no separator.

Test Plan:
- Register write: kind = 0, time = 5, pc = 32'h00003000, reg = 3, data = 32'h0000abcd, out_ready = 1. Expect exactly the 28-character string "^5@00003000: $3 <= 0000abcd#", first character 15 cycles after accept, rec_done on the '#' beat.
- Memory write: kind = 1, time = 1234, pc = 32'h00003010, addr = 32'h0000001c, data = 32'hffffffff. Expect "^1234@00003010: *0000001c <= ffffffff#".
- Boundaries: time = 0 emits "^0@"; time = 16383 saturates and emits "^9999@"; reg = 31 emits "$31"; reg = 0 emits "$0".
- Backpressure: toggle out_ready 0/1 randomly. Expect out_char stable whenever out_valid & !out_ready, and an identical character sequence to the out_ready = 1 run.
- Reset after the 10th character of a record. Expect out_valid = 0 and in_ready = 1 next cycle; the next record is emitted complete and correct.
- Throughput: two records offered back-to-back with IDLE_GAP = 2. Expect the second accept exactly 3 cycles after the first record's '#' is consumed; in_valid asserted while in_ready = 0 is ignored.

Source files
------------

// File: rtl/cpu_trace_emitter.sv
// Serializes CPU write-back trace records into ASCII lines, one character per beat.
// Define TRACE_NEWLINE_EN to append a 8'h0A terminator after each '#'.
module cpu_trace_emitter #(
  parameter int unsigned TIME_MAX = 9999,
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [13:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  out_char,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        rec_done
);

  localparam logic [13:0] TimeMax = 14'(TIME_MAX);
  localparam int unsigned GapW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GapW-1:0] GapLast = (IDLE_GAP > 0) ? GapW'(IDLE_GAP - 1) : '0;

  typedef enum logic [1:0] {StIdle, StConv, StEmit, StGap} state_e;
  typedef enum logic [3:0] {
    FHead, FTime, FAt, FPc, FColon, FSigil, FReg, FAddr, FArrow, FData, FHash, FNl
  } field_e;

  state_e          state_q, state_d;
  field_e          fld_q, fld_d, fld_nxt;
  logic [2:0]      pos_q, pos_d, pos_nxt;
  logic [3:0]      cnt_q, cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [13:0]     bin_q, bin_d;
  logic [15:0]     bcd_q, bcd_d, adj;
  logic            kind_q;
  logic [13:0]     time_q, sat;
  logic [31:0]     pc_q, addr_q, data_q;
  logic [4:0]      reg_q;
  logic [1:0]      reg_tens, t_start;
  logic [3:0]      reg_ones;
  logic [7:0]      ch;
  logic            fld_last, rec_end, accept;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [3:0] nibble(input logic [31:0] w, input logic [2:0] idx);
    return w[{3'd7 - idx, 2'b00} +: 4];
  endfunction

  assign sat = (time_q > TimeMax) ? TimeMax : time_q;

  // Double-dabble correction before each shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    reg_tens = 2'd0;
    reg_ones = reg_q[3:0];
    if (reg_q >= 5'd30) begin
      reg_tens = 2'd3;
      reg_ones = 4'(reg_q - 5'd30);
    end else if (reg_q >= 5'd20) begin
      reg_tens = 2'd2;
      reg_ones = 4'(reg_q - 5'd20);
    end else if (reg_q >= 5'd10) begin
      reg_tens = 2'd1;
      reg_ones = 4'(reg_q - 5'd10);
    end
  end

  // First non-zero time digit; the units digit is always printed.
  always_comb begin
    if (bcd_q[15:12] != 4'd0)     t_start = 2'd0;
    else if (bcd_q[11:8] != 4'd0) t_start = 2'd1;
    else if (bcd_q[7:4] != 4'd0)  t_start = 2'd2;
    else                          t_start = 2'd3;
  end

  always_comb begin
    ch       = 8'h00;
    fld_last = 1'b0;
    fld_nxt  = FHead;
    pos_nxt  = 3'd0;
    rec_end  = 1'b0;
    unique case (fld_q)
      FHead: begin
        ch = "^"; fld_last = 1'b1; fld_nxt = FTime; pos_nxt = {1'b0, t_start};
      end
      FTime: begin
        ch = {4'h3, bcd_q[{2'd3 - pos_q[1:0], 2'b00} +: 4]};
        fld_last = (pos_q == 3'd3); fld_nxt = FAt;
      end
      FAt: begin
        ch = "@"; fld_last = 1'b1; fld_nxt = FPc;
      end
      FPc: begin
        ch = hex_char(nibble(pc_q, pos_q)); fld_last = (pos_q == 3'd7); fld_nxt = FColon;
      end
      FColon: begin
        ch = (pos_q == 3'd0) ? ":" : " "; fld_last = (pos_q == 3'd1); fld_nxt = FSigil;
      end
      FSigil: begin
        ch       = kind_q ? "*" : "$";
        fld_last = 1'b1;
        fld_nxt  = kind_q ? FAddr : FReg;
        pos_nxt  = (kind_q || reg_tens != 2'd0) ? 3'd0 : 3'd1;
      end
      FReg: begin
        ch = (pos_q == 3'd0) ? {6'h0c, reg_tens} : {4'h3, reg_ones};
        fld_last = (pos_q == 3'd1); fld_nxt = FArrow;
      end
      FAddr: begin
        ch = hex_char(nibble(addr_q, pos_q)); fld_last = (pos_q == 3'd7); fld_nxt = FArrow;
      end
      FArrow: begin
        unique case (pos_q[1:0])
          2'd0:    ch = " ";
          2'd1:    ch = "<";
          2'd2:    ch = "=";
          default: ch = " ";
        endcase
        fld_last = (pos_q == 3'd3); fld_nxt = FData;
      end
      FData: begin
        ch = hex_char(nibble(data_q, pos_q)); fld_last = (pos_q == 3'd7); fld_nxt = FHash;
      end
      FHash: begin
        ch = "#"; fld_last = 1'b1;
`ifdef TRACE_NEWLINE_EN
        fld_nxt = FNl;
`else
        rec_end = 1'b1;
`endif
      end
      FNl: begin
        ch = 8'h0a; fld_last = 1'b1; rec_end = 1'b1;
      end
      default: ch = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    fld_d     = fld_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_char  = 8'h00;
    busy      = 1'b1;
    rec_done  = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = StConv;
          cnt_d   = 4'd0;
        end
      end
      StConv: begin
        // Step 0 loads the saturated time; steps 1..14 shift.
        if (cnt_q == 4'd0) begin
          bin_d = sat;
          bcd_d = '0;
          cnt_d = 4'd1;
        end else begin
          {bcd_d, bin_d} = {adj, bin_q} << 1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd14) begin
            state_d = StEmit;
            fld_d   = FHead;
            pos_d   = 3'd0;
          end
        end
      end
      StEmit: begin
        out_valid = 1'b1;
        out_char  = ch;
        if (out_ready) begin
          if (fld_last) begin
            fld_d = fld_nxt;
            pos_d = pos_nxt;
          end else begin
            pos_d = pos_q + 3'd1;
          end
          if (rec_end) begin
            rec_done = 1'b1;
            gap_d    = '0;
            state_d  = (IDLE_GAP > 0) ? StGap : StIdle;
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StIdle;
        else                  gap_d = gap_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      fld_q   <= FHead;
      pos_q   <= 3'd0;
      cnt_q   <= 4'd0;
      gap_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q <= 1'b0;
      time_q <= '0;
      pc_q   <= '0;
      reg_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      kind_q <= in_kind;
      time_q <= in_time;
      pc_q   <= in_pc;
      reg_q  <= in_reg;
      addr_q <= in_addr;
      data_q <= in_data;
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Bench for cpu_trace_emitter: scoreboard of expected characters, popped as beats are consumed.
module tb_cpu_trace_emitter;

  localparam int Gap   = 2;
  localparam int Bound = 3000;
`ifdef TRACE_NEWLINE_EN
  localparam logic [7:0] EndCh = 8'h0a;
  localparam int Extra = 1;
`else
  localparam logic [7:0] EndCh = 8'h23;
  localparam int Extra = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_kind = 1'b0;
  logic [13:0] in_time = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_reg = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [7:0]  out_char;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        rec_done;

  cpu_trace_emitter #(.TIME_MAX(9999), .IDLE_GAP(Gap)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg), .in_addr(in_addr), .in_data(in_data),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .rec_done(rec_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  logic [7:0] prev_char;
  bit   prev_stall = 0;
  bit   seen_valid = 0;
  int   first_valid_cyc = 0;
  int   rec_chars = 0;
  int   done_cnt = 0;
  int   done_edge = 0;
  int   stall_cnt = 0;

  // Monitor: pops the scoreboard on every consumed beat and checks stall stability.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_char !== prev_char) begin
          n_fail++;
          $display("FAIL stall_hold: out_valid=%b out_char=%h, required 1 and %h",
                   out_valid, out_char, prev_char);
        end
      end
      if (out_valid === 1'b1 && !seen_valid) begin
        seen_valid = 1;
        first_valid_cyc = cyc;
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL char_extra: got %h, required no character", out_char);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_char !== mon_e || rec_done !== (mon_e == EndCh)) begin
            n_fail++;
            $display("FAIL char_seq: char=%h rec_done=%b, required %h and %b",
                     out_char, rec_done, mon_e, (mon_e == EndCh));
          end
        end
        rec_chars++;
      end
      if (out_valid === 1'b1 && !out_ready) stall_cnt++;
      if (rec_done === 1'b1) begin
        done_cnt++;
        done_edge = cyc + 1;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_char  = out_char;
    end
  end

  function automatic int push_expected(input logic k, input logic [13:0] t,
      input logic [31:0] pc, input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
    string s;
    int unsigned tv;
    tv = (t > 14'd9999) ? 9999 : int'(t);
    s = $sformatf("^%0d@%08h: ", tv, pc);
    if (k) s = {s, $sformatf("*%08h", a)};
    else   s = {s, $sformatf("$%0d", r)};
    s = {s, $sformatf(" <= %08h#", d)};
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (Extra == 1) exp_q.push_back(8'h0a);
    return s.len() + Extra;
  endfunction

  task automatic send(input logic k, input logic [13:0] t, input logic [31:0] pc,
      input logic [4:0] r, input logic [31:0] a, input logic [31:0] d,
      output int acc_edge, output int n);
    int w;
    w = 0;
    @(posedge clk); #1;
    in_kind = k; in_time = t; in_pc = pc; in_reg = r; in_addr = a; in_data = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < Bound) begin
      @(negedge clk);
      w++;
    end
    if (w >= Bound) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
    end
    acc_edge = cyc + 1;
    n = push_expected(k, t, pc, r, a, d);
    seen_valid = 0;
    rec_chars = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    @(negedge clk); #1;
    while (!(exp_q.size() == 0 && in_ready === 1'b1) && w < Bound) begin
      @(negedge clk); #1;
      w++;
    end
    if (w >= Bound) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d chars left, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks += 5;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: %b, required 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: %b, required 0", out_valid); end
    if (out_char !== 8'h00) begin n_fail++; $display("FAIL rst_out_char: %h, required 00", out_char); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: %b, required 0", busy); end
    if (rec_done !== 1'b0) begin n_fail++; $display("FAIL rst_rec_done: %b, required 0", rec_done); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reg_write();
    int acc, n, d0;
    out_ready = 1'b1;
    d0 = done_cnt;
    send(1'b0, 14'd5, 32'h0000_3000, 5'd3, 32'h0, 32'h0000_abcd, acc, n);
    @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reg_busy: %b, required 1", busy); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reg_in_ready: %b, required 0", in_ready); end
    wait_done();
    n_checks += 4;
    if (first_valid_cyc - acc !== 15) begin
      n_fail++; $display("FAIL reg_latency: %0d, required 15", first_valid_cyc - acc);
    end
    if (rec_chars !== 28 + Extra) begin
      n_fail++; $display("FAIL reg_length: %0d, required %0d", rec_chars, 28 + Extra);
    end
    if (done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL reg_done_cnt: %0d, required 1", done_cnt - d0);
    end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reg_busy_end: %b, required 0", busy); end
  endtask

  task automatic test_mem_write();
    int acc, n;
    send(1'b1, 14'd1234, 32'h0000_3010, 5'd0, 32'h0000_001c, 32'hffff_ffff, acc, n);
    wait_done();
    n_checks += 2;
    if (first_valid_cyc - acc !== 15) begin
      n_fail++; $display("FAIL mem_latency: %0d, required 15", first_valid_cyc - acc);
    end
    if (rec_chars !== 38 + Extra) begin
      n_fail++; $display("FAIL mem_length: %0d, required %0d", rec_chars, 38 + Extra);
    end
  endtask

  task automatic test_boundaries();
    logic [13:0] tv[4] = '{14'd0, 14'd16383, 14'd7, 14'd10000};
    logic [4:0]  rv[4] = '{5'd1, 5'd31, 5'd0, 5'd19};
    logic        kv[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int acc, n;
    for (int i = 0; i < 4; i++) begin
      send(kv[i], tv[i], 32'h89ab_cdef + i, rv[i], 32'hdead_0000 + i, 32'h0123_4567 * (i + 1),
           acc, n);
      wait_done();
      n_checks++;
      if (rec_chars !== n) begin
        n_fail++; $display("FAIL bound_length_%0d: %0d, required %0d", i, rec_chars, n);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, n, w, s0;
    s0 = stall_cnt;
    send(1'b0, 14'd5, 32'h0000_3000, 5'd3, 32'h0, 32'h0000_abcd, acc, n);
    w = 0;
    while (!(exp_q.size() == 0 && in_ready === 1'b1) && w < Bound) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      w++;
    end
    out_ready = 1'b1;
    n_checks += 3;
    if (w >= Bound) begin n_fail++; $display("FAIL bp_timeout: %0d left, required 0", exp_q.size()); end
    if (stall_cnt == s0) begin n_fail++; $display("FAIL bp_stalls: 0 stalls, required >0"); end
    if (rec_chars !== n) begin n_fail++; $display("FAIL bp_length: %0d, required %0d", rec_chars, n); end
  endtask

  task automatic test_reset_mid();
    int acc, n, w;
    out_ready = 1'b1;
    send(1'b1, 14'd42, 32'h1111_2222, 5'd0, 32'h3333_4444, 32'h5555_6666, acc, n);
    w = 0;
    while (rec_chars < 10 && w < Bound) begin
      @(negedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: %b, required 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: %b, required 1", in_ready); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: %b, required 0", busy); end
    send(1'b0, 14'd987, 32'hcafe_f00d, 5'd27, 32'h0, 32'h0bad_beef, acc, n);
    wait_done();
    n_checks++;
    if (rec_chars !== n) begin n_fail++; $display("FAIL mid_length: %0d, required %0d", rec_chars, n); end
  endtask

  task automatic test_back_to_back();
    int acc2, n, w, d0;
    out_ready = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    in_kind = 1'b0; in_time = 14'd77; in_pc = 32'h0000_4000; in_reg = 5'd12;
    in_addr = 32'h0; in_data = 32'h1234_5678;
    in_valid = 1'b1;
    @(negedge clk);
    n = push_expected(1'b0, 14'd77, 32'h0000_4000, 5'd12, 32'h0, 32'h1234_5678);
    @(posedge clk); #1;
    // Second record is held on the inputs while the first is in flight.
    in_kind = 1'b1; in_time = 14'd300; in_pc = 32'h0000_4004; in_reg = 5'd9;
    in_addr = 32'haaaa_bbbb; in_data = 32'hc0de_0001;
    w = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < Bound) begin
      @(negedge clk);
      w++;
    end
    acc2 = cyc + 1;
    n_checks += 2;
    if (w >= Bound) begin n_fail++; $display("FAIL b2b_timeout: in_ready=%b, required 1", in_ready); end
    if (acc2 - done_edge !== Gap + 1) begin
      n_fail++; $display("FAIL b2b_gap: %0d cycles, required %0d", acc2 - done_edge, Gap + 1);
    end
    n = push_expected(1'b1, 14'd300, 32'h0000_4004, 5'd9, 32'haaaa_bbbb, 32'hc0de_0001);
    rec_chars = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done();
    n_checks += 2;
    if (rec_chars !== n) begin n_fail++; $display("FAIL b2b_length: %0d, required %0d", rec_chars, n); end
    if (done_cnt - d0 !== 2) begin
      n_fail++; $display("FAIL b2b_done_cnt: %0d, required 2", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_mem_write();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
